// File: rtl/fixed_point_addsub_pipe.sv
// rtl/fixed_point_addsub_pipe.sv - carry-pipelined fixed-point add/subtract with overflow, saturation and valid/ready
module fixed_point_addsub_pipe #(
  parameter int N        = 32,
  parameter int CHUNK    = 8,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         carry_out,
  output logic         overflow,
  output logic         saturated
);

  localparam int STAGES = N / CHUNK;
  localparam int OPS    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int L      = STAGES - 1;

  logic en;

  // Inter-stage registers; the last stage registers straight into the outputs.
  logic         v_q   [OPS];
  logic         sub_q [OPS];
  logic         cy_q  [OPS];
  logic [N-1:0] a_q   [OPS];
  logic [N-1:0] b_q   [OPS];
  logic [N-1:0] r_q   [OPS];

  logic         n_v   [STAGES];
  logic         n_sub [STAGES];
  logic         n_cy  [STAGES];
  logic [N-1:0] n_a   [STAGES];
  logic [N-1:0] n_b   [STAGES];
  logic [N-1:0] n_r   [STAGES];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0]   sa;
    logic [N-1:0]   sb;
    logic [N-1:0]   sr;
    logic           sv;
    logic           ssub;
    logic           scy;
    logic [CHUNK:0] sum;
    logic [N-1:0]   res;

    if (k == 0) begin : g_src
      // Subtraction is a + ~b + ~borrow_in; b is inverted once here and carried inverted.
      assign sv   = in_valid;
      assign ssub = sub;
      assign sa   = a;
      assign sb   = sub ? ~b : b;
      assign scy  = carry_in ^ sub;
      assign sr   = '0;
    end else begin : g_src
      assign sv   = v_q[k-1];
      assign ssub = sub_q[k-1];
      assign sa   = a_q[k-1];
      assign sb   = b_q[k-1];
      assign scy  = cy_q[k-1];
      assign sr   = r_q[k-1];
    end

    assign sum = {1'b0, sa[k*CHUNK +: CHUNK]} + {1'b0, sb[k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, scy};

    always_comb begin
      res = sr;
      res[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end

    assign n_v[k]   = sv;
    assign n_sub[k] = ssub;
    assign n_cy[k]  = sum[CHUNK];
    assign n_a[k]   = sa;
    assign n_b[k]   = sb;
    assign n_r[k]   = res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OPS; k++) begin
        v_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        v_q[k]   <= n_v[k];
        sub_q[k] <= n_sub[k];
        cy_q[k]  <= n_cy[k];
        a_q[k]   <= n_a[k];
        b_q[k]   <= n_b[k];
        r_q[k]   <= n_r[k];
      end
    end
  end

  logic         carry_flag;
  logic         sign_a;
  logic         sign_b;
  logic         sign_r;
  logic         ovf;
  logic         sat_fire;
  logic [N-1:0] sat_val;
  logic [N-1:0] c_next;

  // Raw adder carry is inverted for subtract to report a borrow.
  assign carry_flag = n_cy[L] ^ n_sub[L];
  assign sign_a     = n_a[L][N-1];
  assign sign_b     = n_b[L][N-1];
  assign sign_r     = n_r[L][N-1];

  always_comb begin
    ovf     = 1'b0;
    sat_val = '0;
    if (SIGNED) begin
      ovf     = (sign_a == sign_b) && (sign_r != sign_a);
      sat_val = sign_a ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      ovf     = carry_flag;
      sat_val = n_sub[L] ? '0 : '1;
    end
    sat_fire = SATURATE && ovf;
    c_next   = sat_fire ? sat_val : n_r[L];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      saturated <= 1'b0;
    end else if (en) begin
      out_valid <= n_v[L];
      if (n_v[L]) begin
        c         <= c_next;
        carry_out <= carry_flag;
        overflow  <= ovf;
        saturated <= sat_fire;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// tb/tb_fixed_point_addsub_pipe.sv - self-checking bench for fixed_point_addsub_pipe (signed/saturating and unsigned/wrapping)
module tb_fixed_point_addsub_pipe;

  localparam int N      = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = N / CHUNK;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic sub = 1'b0;
  logic carry_in = 1'b0;
  logic out_ready = 1'b1;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;

  logic in_ready, out_valid, carry_out, overflow, saturated;
  logic [N-1:0] c;
  logic in_ready2, out_valid2, carry_out2, overflow2, saturated2;
  logic [N-1:0] c2;

  always #5 clk = ~clk;

  fixed_point_addsub_pipe #(.N(N), .CHUNK(CHUNK), .SIGNED(1'b1), .SATURATE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .c(c),
    .carry_out(carry_out), .overflow(overflow), .saturated(saturated)
  );

  fixed_point_addsub_pipe #(.N(N), .CHUNK(CHUNK), .SIGNED(1'b0), .SATURATE(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .sub(sub), .carry_in(carry_in),
    .out_valid(out_valid2), .out_ready(out_ready), .c(c2),
    .carry_out(carry_out2), .overflow(overflow2), .saturated(saturated2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit rnd_done = 1'b0;

  typedef struct {
    logic [31:0] c1;
    logic        co;
    logic        ov1;
    logic        s1;
    logic [31:0] c2;
    logic        ov2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then apply the overflow/saturation rules.
  function automatic exp_t model(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                                 input logic ci);
    exp_t e;
    logic [32:0] u;
    longint tr;
    if (!s) begin
      u  = {1'b0, aa} + {1'b0, bb} + 33'(ci);
      tr = longint'($signed(aa)) + longint'($signed(bb)) + longint'(ci);
    end else begin
      u  = {1'b0, aa} - {1'b0, bb} - 33'(ci);
      tr = longint'($signed(aa)) - longint'($signed(bb)) - longint'(ci);
    end
    e.co  = u[32];
    e.ov1 = (tr > SMAX) || (tr < SMIN);
    e.s1  = e.ov1;
    e.c1  = e.ov1 ? ((tr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : u[31:0];
    e.c2  = u[31:0];
    e.ov2 = e.co;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid_pair", out_valid2, out_valid);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          mon_e = exp_q[0];
          chk("c_signed", c, mon_e.c1);
          chk("carry_signed", carry_out, mon_e.co);
          chk("ovf_signed", overflow, mon_e.ov1);
          chk("sat_signed", saturated, mon_e.s1);
          chk("c_unsigned", c2, mon_e.c2);
          chk("carry_unsigned", carry_out2, mon_e.co);
          chk("ovf_unsigned", overflow2, mon_e.ov2);
          chk("sat_unsigned", saturated2, 1'b0);
          if (out_ready) mon_e = exp_q.pop_front();
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(sub, a, b, carry_in));
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_c"}, c, 32'h0);
    chk({tag, "_carry"}, carry_out, 1'b0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_sat"}, saturated, 1'b0);
    chk({tag, "_valid2"}, out_valid2, 1'b0);
    chk({tag, "_c2"}, c2, 32'h0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic send(input logic s, input logic [31:0] aa, input logic [31:0] bb, input logic ci);
    bit done;
    int t;
    done = 1'b0;
    t = 0;
    sub = s; a = aa; b = bb; carry_in = ci; in_valid = 1'b1;
    while (!done && t < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!done) chk("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic single_op(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                           input logic ci, input logic [31:0] ec, input logic eco,
                           input logic eov, input logic esat, input logic [31:0] ec2,
                           input logic eov2);
    sub = s; a = aa; b = bb; carry_in = ci; in_valid = 1'b1;
    @(negedge clk);
    chk("single_accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      @(negedge clk);
      chk("latency_early", out_valid, 1'b0);
    end
    @(negedge clk);
    chk("latency_valid", out_valid, 1'b1);
    chk("lit_c", c, ec);
    chk("lit_carry", carry_out, eco);
    chk("lit_ovf", overflow, eov);
    chk("lit_sat", saturated, esat);
    chk("lit_c2", c2, ec2);
    chk("lit_ovf2", overflow2, eov2);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: rnd32 = 32'h7FFF_FFFF;
      1: rnd32 = 32'h8000_0000;
      2: rnd32 = 32'hFFFF_FFFF;
      3: rnd32 = 32'h0000_0000;
      default: rnd32 = $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    single_op(1'b1, 32'h1, 32'h0, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 32'h1, 1'b0);
    single_op(1'b1, 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    single_op(1'b1, 32'h5, 32'h3, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h1, 1'b0);
    single_op(1'b0, 32'h0000_00FF, 32'h1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
    single_op(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
    single_op(1'b1, 32'h8000_0000, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0);
    single_op(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    single_op(1'b0, 32'h0000_00FF, 32'h00FF_FF00, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 32'h0100_0000, 1'b0);

    // Back-to-back stream with a 3-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(1'($urandom_range(0, 1)), rnd32(), rnd32(), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with one result presented and three operations in flight.
    for (int i = 0; i < 4; i++) send(1'b0, 32'h1000 + 32'(i), 32'h1, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    check_idle_outputs("midreset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_idle", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    single_op(1'b0, 32'h2, 32'h3, 1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 32'h6, 1'b0);

    // Randomized traffic with bubbles and random backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(1'($urandom_range(0, 1)), rnd32(), rnd32(), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_addsub_pipe.md
Name: fixed_point_addsub_pipe

Overview:
- Parametrised, carry-pipelined fixed-point add/subtract unit; next generation of the combinational ripple-carry subtractor.
- Splits the N-bit carry chain into CHUNK-bit stages with a registered carry between stages, giving throughput of one operation per clock.
- Adds a runtime add/sub select, signed/unsigned overflow detection, optional saturation and a valid/ready handshake on both sides.
- Sits between operand sources and the fixed-point datapath.

Parameters:
- N, 32, data path width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per pipeline stage. Derived value STAGES = N/CHUNK, which is also the latency.
- SIGNED, 1, 1 = two's-complement overflow rules; 0 = unsigned rules.
- SATURATE, 1, 1 = clamp the result on overflow; 0 = wrap.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands and controls are valid.
- in_ready, output, 1, the unit accepts the input this cycle.
- a, input, N, minuend / first addend.
- b, input, N, subtrahend / second addend.
- sub, input, 1, 0 = add, 1 = subtract.
- carry_in, input, 1, carry-in for add; borrow-in for subtract.
- out_valid, output, 1, the result is valid.
- out_ready, input, 1, the consumer accepts the result.
- c, output, N, result.
- carry_out, output, 1, unsigned carry-out (add) or borrow-out (sub).
- overflow, output, 1, the result overflowed per the SIGNED rules.
- saturated, output, 1, c was clamped.

Behaviour:
- Reset: asynchronous when rst_n is low. Clears all stage valid bits, carries and data registers. Outputs while in reset: out_valid=0, c=0, carry_out=0, overflow=0, saturated=0. in_ready=1 once out_valid=0.
- Arithmetic, add: {carry_out,c} = a + b + carry_in.
- Arithmetic, subtract: the unit internally computes a + ~b + ~carry_in, so c = a - b - carry_in (mod 2^N). carry_out = borrow = 1 when unsigned a < b + carry_in.
- overflow, SIGNED=1: the operand signs, with b's sign inverted for sub, match and the result sign differs.
- overflow, SIGNED=0: overflow = carry_out.
- Saturation (SATURATE=1 and overflow=1):
  - Signed: c = 0x7FF..F if the true result is positive, 0x800..0 if negative.
  - Unsigned add: all ones.
  - Unsigned sub: 0.
  - saturated=1 in these cases; otherwise saturated=0.
  - carry_out and overflow always report the raw (unsaturated) condition.
- Pipeline structure:
  - Stage k (0..STAGES-1) resolves bits [k*CHUNK +: CHUNK] using the carry registered from stage k-1; stage 0 uses the effective carry-in.
  - Unresolved upper operand chunks and sub are delayed alongside the data.
  - Lower result chunks are skewed forward so the final register presents an aligned c.
  - Overflow and saturation are evaluated from stage STAGES-1's chunk and carries and registered into the output stage.
- Latency: an input accepted at edge t (in_valid && in_ready) appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES register stages. CHUNK=N gives latency 1.
- Handshake and stall:
  - Global enable en = !out_valid || out_ready.
  - in_ready = en.
  - All stages advance only when en=1; bubbles propagate as valid=0.
  - While out_valid && !out_ready, c, carry_out, overflow and saturated hold stable.
  - No input is dropped and no result is duplicated; results leave in acceptance order.
- Boundary cases:
  - Simultaneous accept and emit in one cycle are allowed; sustains one operation per clock.
  - in_valid=0 with en=1 inserts a bubble.
  - Inputs are ignored when in_ready=0.
  - Reset mid-operation discards all in-flight results; the first post-reset out_valid comes only from a post-reset input.
- Outputs are undefined-free: registers hold their last value when out_valid=0.

Test Plan:
All scenarios use N=32, CHUNK=8 (latency 4), SIGNED=1, SATURATE=1 unless stated.
1. sub=1, a=1, b=0, cin=0 -> c=0x00000001, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after accept.
2. sub=1, a=0, b=1 -> c=0xFFFFFFFF, carry_out=1, overflow=0, saturated=0. Then sub=1, a=5, b=3, cin=1 -> c=1.
3. Add a=0x000000FF, b=1 -> c=0x00000100 (cross-chunk carry). Add a=0x7FFFFFFF, b=1 -> c=0x7FFFFFFF, overflow=1, saturated=1.
4. sub=1, a=0x80000000, b=1 -> c=0x80000000, saturated=1. With SATURATE=0, SIGNED=0: add 0xFFFFFFFF+1 -> c=0, carry_out=1, overflow=1, saturated=0.
5. Stream 8 back-to-back ops while out_ready is held low for 3 cycles mid-stream -> in_ready=0 during the stall, c held stable, all 8 results in order, no loss or duplicates.
6. Assert rst_n low with 3 ops in flight -> out_valid=0 and c=0 immediately. After release, only new inputs produce outputs, each after 4 cycles.
